// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/op encodings and master count for the memory arbiter.
package mem_arb_pkg;
    localparam int NUM_MASTERS = 2;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
    typedef enum logic {OP_READ = 1'b0, OP_WRITE = 1'b1} op_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick; on a tie the master that did not win last time is chosen.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic                   last_grant_i,
    output logic                   grant_o,
    output logic                   valid_o
);
    assign valid_o = |req_i;
    assign grant_o = &req_i ? ~last_grant_i : req_i[1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between two masters with round-robin grant,
// latched transactions, registered per-master responses and a per-transaction timeout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] ERROR_DATA     = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_read_request,
    input  logic                  m0_write_request,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_write_data,
    output logic [DATA_WIDTH-1:0] m0_read_data,
    output logic                  m0_response,
    output logic                  m0_error,
    input  logic                  m1_read_request,
    input  logic                  m1_write_request,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_write_data,
    output logic [DATA_WIDTH-1:0] m1_read_data,
    output logic                  m1_response,
    output logic                  m1_error,
    output logic                  mem_read_request,
    output logic                  mem_write_request,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    input  logic                  mem_response,
    output logic                  grant,
    output logic                  busy
);
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    state_t                                 state_q;
    op_t                                    op_q;
    logic                                   grant_q, last_grant_q;
    logic [ADDR_WIDTH-1:0]                  addr_q;
    logic [DATA_WIDTH-1:0]                  wdata_q;
    logic [CW-1:0]                          cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] rdata_q;
    logic [NUM_MASTERS-1:0]                 resp_q, err_q;
    logic [NUM_MASTERS-1:0]                 req;
    logic                                   arb_grant, arb_valid, sel_wr, timeout_hit;

    assign req         = {m1_read_request | m1_write_request, m0_read_request | m0_write_request};
    assign sel_wr      = arb_grant ? m1_write_request : m0_write_request;
    assign cnt_d       = &cnt_q ? cnt_q : cnt_q + 1'b1;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    rr_arbiter2 u_rr (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .valid_o      (arb_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= OP_READ;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            resp_q       <= '0;
            err_q        <= '0;
        end else begin
            case (state_q)
                IDLE: if (arb_valid) begin
                    grant_q      <= arb_grant;
                    last_grant_q <= arb_grant;
                    addr_q       <= arb_grant ? m1_addr : m0_addr;
                    wdata_q      <= arb_grant ? m1_write_data : m0_write_data;
                    op_q         <= sel_wr ? OP_WRITE : OP_READ;
                    cnt_q        <= '0;
                    state_q      <= BUSY;
                end
                BUSY: begin
                    cnt_q <= cnt_d;
                    // a real response beats a timeout landing in the same cycle
                    if (mem_response || timeout_hit) begin
                        resp_q[grant_q] <= 1'b1;
                        err_q[grant_q]  <= !mem_response;
                        if (!mem_response)
                            rdata_q[grant_q] <= ERROR_DATA;
                        else if (op_q == OP_READ)
                            rdata_q[grant_q] <= mem_read_data;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    resp_q  <= '0;
                    err_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_read_request  = (state_q == BUSY) && (op_q == OP_READ);
    assign mem_write_request = (state_q == BUSY) && (op_q == OP_WRITE);
    assign mem_addr          = addr_q;
    assign mem_write_data    = wdata_q;
    assign m0_read_data      = rdata_q[0];
    assign m1_read_data      = rdata_q[1];
    assign m0_response       = resp_q[0];
    assign m1_response       = resp_q[1];
    assign m0_error          = err_q[0];
    assign m1_error          = err_q[1];
    assign grant             = grant_q;
    assign busy              = state_q != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench; stimulus queues expected responses, a monitor pops and compares them.
module tb_mem_arbiter;
    localparam int          TO = 8;
    localparam logic [31:0] ED = 32'hDEAD_BEEF;

    logic        clk = 1'b0, rst = 1'b1;
    logic        m0_read_request, m0_write_request, m1_read_request, m1_write_request;
    logic [31:0] m0_addr, m0_write_data, m1_addr, m1_write_data;
    logic [31:0] m0_read_data, m1_read_data, mem_addr, mem_write_data, mem_read_data;
    logic        m0_response, m0_error, m1_response, m1_error;
    logic        mem_read_request, mem_write_request, mem_response, grant, busy;

    logic        mem_en = 1'b1;
    int          mem_lat = 1;
    logic        rec_rd, rec_wr;
    logic [31:0] rec_addr, rec_wdata;

    typedef struct {int m; logic err; logic [31:0] rdata;} exp_t;
    exp_t q[$];
    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO), .ERROR_DATA(ED)) dut (
        .clk(clk), .rst(rst),
        .m0_read_request(m0_read_request), .m0_write_request(m0_write_request),
        .m0_addr(m0_addr), .m0_write_data(m0_write_data), .m0_read_data(m0_read_data),
        .m0_response(m0_response), .m0_error(m0_error),
        .m1_read_request(m1_read_request), .m1_write_request(m1_write_request),
        .m1_addr(m1_addr), .m1_write_data(m1_write_data), .m1_read_data(m1_read_data),
        .m1_response(m1_response), .m1_error(m1_error),
        .mem_read_request(mem_read_request), .mem_write_request(mem_write_request),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .mem_response(mem_response), .grant(grant), .busy(busy)
    );

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h10) ? 32'hCAFEBABE : {16'h5A5A, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int m, input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        if (m == 0) begin
            m0_read_request = rd; m0_write_request = wr; m0_addr = a; m0_write_data = wd;
        end else begin
            m1_read_request = rd; m1_write_request = wr; m1_addr = a; m1_write_data = wd;
        end
    endtask

    task automatic wait_resp(input int m, output int n, output logic [31:0] c1_addr, output logic c1_rd, output logic c1_wr);
        bit done;
        done = 0; n = 0; c1_addr = '0; c1_rd = 0; c1_wr = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                c1_addr = mem_addr; c1_rd = mem_read_request; c1_wr = mem_write_request;
            end
            done = (m == 0) ? m0_response : m1_response;
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL resp_wait: master %0d got no response within %0d cycles", m, n);
        end
    endtask

    task automatic do_txn(input int m, input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic e_err, input logic [31:0] e_rd,
                          output int lat, output logic [31:0] c1_addr, output logic c1_rd, output logic c1_wr);
        @(negedge clk);
        drive(m, rd, wr, a, wd);
        q.push_back('{m, e_err, e_rd});
        wait_resp(m, lat, c1_addr, c1_rd, c1_wr);
        drive(m, 1'b0, 1'b0, a, wd);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // memory: responds after mem_lat cycles of an active request, records what it served
    initial begin
        int cnt;
        cnt = 0; mem_response = 0; mem_read_data = '0;
        rec_rd = 0; rec_wr = 0; rec_addr = '0; rec_wdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_response) begin
                mem_response = 0; cnt = 0;
            end else if ((mem_read_request || mem_write_request) && mem_en) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    mem_response = 1; mem_read_data = mem_val(mem_addr);
                    rec_rd = mem_read_request; rec_wr = mem_write_request;
                    rec_addr = mem_addr; rec_wdata = mem_write_data;
                    cnt = 0;
                end
            end else cnt = 0;
        end
    end

    initial begin
        logic prev, any;
        exp_t e;
        prev = 0;
        forever begin
            @(negedge clk);
            if (rst) prev = 0;
            else begin
                any = m0_response | m1_response;
                if (any) begin
                    check("dual_resp", {31'b0, m0_response & m1_response}, 32'd0);
                    check("pulse_width", {31'b0, prev}, 32'd0);
                    if (q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_resp: m0=%b m1=%b with nothing expected", m0_response, m1_response);
                    end else begin
                        e = q.pop_front();
                        check("resp_master", m1_response ? 32'd1 : 32'd0, e.m);
                        check("grant", {31'b0, grant}, e.m);
                        check("error", {31'b0, m1_response ? m1_error : m0_error}, {31'b0, e.err});
                        check("rdata", m1_response ? m1_read_data : m0_read_data, e.rdata);
                    end
                end
                prev = any;
            end
        end
    end

    initial begin
        int lat, c0, c1, k;
        logic [31:0] a1;
        logic r1, w1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("rst_mem_rd", {31'b0, mem_read_request}, 0);
        check("rst_mem_wr", {31'b0, mem_write_request}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_grant", {31'b0, grant}, 0);
        check("rst_m0_resp", {31'b0, m0_response}, 0);
        check("rst_m1_err", {31'b0, m1_error}, 0);
        check("rst_m0_rdata", m0_read_data, 0);
        check("rst_m1_rdata", m1_read_data, 0);
        rst = 1'b0;

        // reset lands while an m0 write is stuck in BUSY
        @(negedge clk);
        mem_en = 0;
        drive(0, 0, 1, 32'h50, 32'h55);
        repeat (3) @(negedge clk);
        check("t1_pre_wr", {31'b0, mem_write_request}, 1);
        check("t1_pre_busy", {31'b0, busy}, 1);
        rst = 1'b1;
        #1;
        check("t1_rst_wr", {31'b0, mem_write_request}, 0);
        check("t1_rst_busy", {31'b0, busy}, 0);
        drive(0, 0, 0, 32'h50, 32'h55);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mem_en = 1;
        do_txn(1, 1, 0, 32'h8, 0, 0, mem_val(32'h8), lat, a1, r1, w1);
        check("t1_m1_addr", a1, 32'h8);

        // single read, zero-wait memory
        do_txn(0, 1, 0, 32'h10, 0, 0, 32'hCAFEBABE, lat, a1, r1, w1);
        check("t2_latency", lat, 2);
        check("t2_c1_addr", a1, 32'h10);
        check("t2_c1_rd", {31'b0, r1}, 1);
        check("t2_c1_wr", {31'b0, w1}, 0);
        @(negedge clk);
        check("t2_resp_drop", {31'b0, m0_response}, 0);
        check("t2_err_drop", {31'b0, m0_error}, 0);
        check("t2_rdata_hold", m0_read_data, 32'hCAFEBABE);

        // contention from reset: grants must alternate starting with m0
        do_reset();
        @(negedge clk);
        drive(0, 1, 0, 32'h100, 0);
        drive(1, 1, 0, 32'h104, 0);
        for (int i = 0; i < 6; i++) q.push_back('{i % 2, 1'b0, mem_val(i % 2 ? 32'h104 : 32'h100)});
        c0 = 0; c1 = 0; k = 0;
        while (c0 + c1 < 6 && k < 100) begin
            @(negedge clk);
            k++;
            if (m0_response) begin
                c0++;
                if (c0 == 3) drive(0, 0, 0, 32'h100, 0);
            end
            if (m1_response) begin
                c1++;
                if (c1 == 3) drive(1, 0, 0, 32'h104, 0);
            end
        end
        check("t3_count", c0 + c1, 6);

        // timeout on an m1 read, then a normal m0 read
        mem_en = 0;
        do_txn(1, 1, 0, 32'h60, 0, 1, ED, lat, a1, r1, w1);
        check("t4_latency", lat, TO + 1);
        mem_en = 1;
        do_txn(0, 1, 0, 32'h70, 0, 0, mem_val(32'h70), lat, a1, r1, w1);
        check("t4_after_lat", lat, 2);

        // m0 abandons its write mid-BUSY; latched values must still reach memory
        mem_lat = 3;
        @(negedge clk);
        drive(0, 0, 1, 32'h20, 32'h1234);
        q.push_back('{0, 1'b0, mem_val(32'h70)});
        @(negedge clk);
        drive(0, 0, 0, 32'h40, 32'hFFFF);
        wait_resp(0, lat, a1, r1, w1);
        check("t5_rec_wr", {31'b0, rec_wr}, 1);
        check("t5_rec_addr", rec_addr, 32'h20);
        check("t5_rec_wdata", rec_wdata, 32'h1234);
        repeat (4) @(negedge clk);
        check("t5_q_empty", q.size(), 0);
        mem_lat = 1;

        // read and write both high: write wins, read data untouched
        do_txn(1, 1, 1, 32'h30, 32'h77, 0, ED, lat, a1, r1, w1);
        check("t6_c1_rd", {31'b0, r1}, 0);
        check("t6_c1_wr", {31'b0, w1}, 1);
        check("t6_rec_rd", {31'b0, rec_rd}, 0);
        check("t6_rec_addr", rec_addr, 32'h30);
        check("t6_rec_wdata", rec_wdata, 32'h77);

        repeat (3) @(negedge clk);
        check("final_q_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
